// File: rtl/battle_stats_loader.sv
// battle_stats_loader
//
// Walks the combinational species/move table for one species and holds the
// resulting battler for the battle FSM. A load drives the species address,
// captures the 12-byte species record, then drives each of the four move
// addresses in turn and captures each 5-byte move record. Between loads the
// block tracks the remaining PP of every move slot.
//
// Optional feature macro: BATTLE_STATS_REFILL_EN
//   When defined, adds the 'refill' input, which restores every slot's PP to
//   its base value while idle.
//
// Ports:
//   clk, reset_n       system clock, asynchronous active-low reset
//   start, mon_sel     load request and species index (sampled in IDLE)
//   use_move, move_idx PP consume request and the slot it targets
//   refill             PP restore request (only with BATTLE_STATS_REFILL_EN)
//   pokemon_addr       species address to the table
//   move_addr          move address to the table
//   pokemon_data       species record from the table (96 bits)
//   move_data          move record from the table (40 bits)
//   busy, done         load in progress / one-cycle completion pulse
//   mon_type1/2        latched species types
//   mon_base           {HP,Atk,Def,SpA,SpD,Spe}, HP in the MSBs
//   move_info          per slot {type,category,power,accuracy}
//   pp_max, pp_cur     per slot base PP and remaining PP
//   pp_empty           per slot pp_cur == 0
//   all_pp_empty       every slot is out of PP

module battle_stats_loader #(
  // Fixed by the table format: a species record holds exactly four move
  // addresses. Other values are unsupported.
  parameter int NUM_MOVES = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [2:0]                 mon_sel,
  input  logic                       use_move,
  input  logic [1:0]                 move_idx,
`ifdef BATTLE_STATS_REFILL_EN
  input  logic                       refill,
`endif
  output logic [2:0]                 pokemon_addr,
  output logic [4:0]                 move_addr,
  input  logic [95:0]                pokemon_data,
  input  logic [39:0]                move_data,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 mon_type1,
  output logic [7:0]                 mon_type2,
  output logic [47:0]                mon_base,
  output logic [NUM_MOVES-1:0][31:0] move_info,
  output logic [NUM_MOVES-1:0][7:0]  pp_max,
  output logic [NUM_MOVES-1:0][7:0]  pp_cur,
  output logic [NUM_MOVES-1:0]       pp_empty,
  output logic                       all_pp_empty
);

  // state     | meaning
  // ----------+---------------------------------------------------------
  // IDLE      | battler held; PP use (and refill) accepted; waits for start
  // FETCH_MON | species address on the table; species record captured
  // FETCH_MV  | one move record captured per cycle, slot_q = 0..3
  // DONE      | one-cycle completion pulse
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH_MON = 2'd1,
    FETCH_MV  = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [1:0]                 slot_q;
  logic [NUM_MOVES-1:0][4:0]  mv_addr_q;
  logic                       refill_req;

  // Move addresses occupy a full byte in the species record but the table
  // only has 32 move entries, so the top three bits of each are dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{pokemon_data[31:29], pokemon_data[23:21],
                            pokemon_data[15:13], pokemon_data[7:5]};

`ifdef BATTLE_STATS_REFILL_EN
  assign refill_req = refill;
`else
  assign refill_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = FETCH_MON;
      FETCH_MON: state_d = FETCH_MV;
      FETCH_MV:  if (slot_q == 2'd3) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pokemon_addr <= '0;
      move_addr    <= '0;
      slot_q       <= '0;
      mv_addr_q    <= '0;
      mon_type1    <= '0;
      mon_type2    <= '0;
      mon_base     <= '0;
      move_info    <= '0;
      pp_max       <= '0;
      pp_cur       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // start wins over refill and use_move in the same cycle
          if (start) begin
            pokemon_addr <= mon_sel;
          end else if (refill_req) begin
            pp_cur <= pp_max;
          end else if (use_move && !pp_empty[move_idx]) begin
            pp_cur[move_idx] <= pp_cur[move_idx] - 8'd1;
          end
        end
        FETCH_MON: begin
          mon_type1    <= pokemon_data[95:88];
          mon_type2    <= pokemon_data[87:80];
          mon_base     <= pokemon_data[79:32];
          mv_addr_q[0] <= pokemon_data[28:24];
          mv_addr_q[1] <= pokemon_data[20:16];
          mv_addr_q[2] <= pokemon_data[12:8];
          mv_addr_q[3] <= pokemon_data[4:0];
          // the table is combinational, so slot 0 is addressed straight
          // from the record being captured
          move_addr    <= pokemon_data[28:24];
          slot_q       <= 2'd0;
        end
        FETCH_MV: begin
          move_info[slot_q] <= move_data[39:8];
          pp_max[slot_q]    <= move_data[7:0];
          pp_cur[slot_q]    <= move_data[7:0];
          if (slot_q != 2'd3) begin
            move_addr <= mv_addr_q[slot_q + 2'd1];
            slot_q    <= slot_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_MOVES; i++) begin : g_empty
    assign pp_empty[i] = (pp_cur[i] == 8'd0);
  end

  assign all_pp_empty = &pp_empty;

endmodule

// File: tb/tb_battle_stats_loader.sv
module tb_battle_stats_loader;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [2:0]        mon_sel;
  logic              use_move;
  logic [1:0]        move_idx;
`ifdef BATTLE_STATS_REFILL_EN
  logic              refill;
`endif
  logic [2:0]        pokemon_addr;
  logic [4:0]        move_addr;
  logic [95:0]       pokemon_data;
  logic [39:0]       move_data;
  logic              busy;
  logic              done;
  logic [7:0]        mon_type1;
  logic [7:0]        mon_type2;
  logic [47:0]       mon_base;
  logic [3:0][31:0]  move_info;
  logic [3:0][7:0]   pp_max;
  logic [3:0][7:0]   pp_cur;
  logic [3:0]        pp_empty;
  logic              all_pp_empty;

  battle_stats_loader #(.NUM_MOVES(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .mon_sel      (mon_sel),
    .use_move     (use_move),
    .move_idx     (move_idx),
`ifdef BATTLE_STATS_REFILL_EN
    .refill       (refill),
`endif
    .pokemon_addr (pokemon_addr),
    .move_addr    (move_addr),
    .pokemon_data (pokemon_data),
    .move_data    (move_data),
    .busy         (busy),
    .done         (done),
    .mon_type1    (mon_type1),
    .mon_type2    (mon_type2),
    .mon_base     (mon_base),
    .move_info    (move_info),
    .pp_max       (pp_max),
    .pp_cur       (pp_cur),
    .pp_empty     (pp_empty),
    .all_pp_empty (all_pp_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- table contents, kept as named fields ----------------
  logic [7:0] mon_t1 [8];
  logic [7:0] mon_t2 [8];
  logic [7:0] mon_st [8][6];   // HP, Atk, Def, SpA, SpD, Spe
  logic [7:0] mon_mv [8][4];   // move address per slot
  logic [7:0] mv_type [32];
  logic [7:0] mv_cat  [32];
  logic [7:0] mv_pow  [32];
  logic [7:0] mv_acc  [32];
  logic [7:0] mv_pp   [32];

  // combinational table seen by the DUT
  always_comb begin
    pokemon_data = {mon_t1[pokemon_addr], mon_t2[pokemon_addr],
                    mon_st[pokemon_addr][0], mon_st[pokemon_addr][1],
                    mon_st[pokemon_addr][2], mon_st[pokemon_addr][3],
                    mon_st[pokemon_addr][4], mon_st[pokemon_addr][5],
                    mon_mv[pokemon_addr][0], mon_mv[pokemon_addr][1],
                    mon_mv[pokemon_addr][2], mon_mv[pokemon_addr][3]};
    move_data = {mv_type[move_addr], mv_cat[move_addr], mv_pow[move_addr],
                 mv_acc[move_addr], mv_pp[move_addr]};
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct packed {
    logic [7:0]       t1;
    logic [7:0]       t2;
    logic [47:0]      base;
    logic [3:0][31:0] info;
    logic [3:0][7:0]  ppm;
  } exp_t;

  typedef struct packed {
    logic [3:0][7:0] cur;
    logic [3:0]      empty;
    logic            all_e;
  } pp_exp_t;

  exp_t    exp_q [$];
  pp_exp_t pp_q  [$];
  event    pp_chk;

  int pp_model    [4];
  int ppmax_model [4];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic exp_t model_load(input int s);
    exp_t e;
    int a;
    e.t1   = mon_t1[s];
    e.t2   = mon_t2[s];
    e.base = {mon_st[s][0], mon_st[s][1], mon_st[s][2],
              mon_st[s][3], mon_st[s][4], mon_st[s][5]};
    for (int k = 0; k < 4; k++) begin
      a = int'(mon_mv[s][k]) % 32;
      e.info[k] = {mv_type[a], mv_cat[a], mv_pow[a], mv_acc[a]};
      e.ppm[k]  = mv_pp[a];
    end
    return e;
  endfunction

  // load monitor: one expected battler per done pulse
  exp_t em;
  always @(negedge clk) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending load (t=%0t)", $time);
      end else begin
        em = exp_q.pop_front();
        chk("mon_type1", 128'(mon_type1), 128'(em.t1));
        chk("mon_type2", 128'(mon_type2), 128'(em.t2));
        chk("mon_base",  128'(mon_base),  128'(em.base));
        chk("move_info", 128'(move_info), 128'(em.info));
        chk("pp_max",    128'(pp_max),    128'(em.ppm));
        chk("pp_cur_load", 128'(pp_cur),  128'(em.ppm));
      end
    end
  end

  // PP monitor: compares each requested PP snapshot
  pp_exp_t pm;
  always @(pp_chk) begin
    if (pp_q.size() != 0) begin
      pm = pp_q.pop_front();
      chk("pp_cur",       128'(pp_cur),       128'(pm.cur));
      chk("pp_empty",     128'(pp_empty),     128'(pm.empty));
      chk("all_pp_empty", 128'(all_pp_empty), 128'(pm.all_e));
    end
  end

  task automatic pp_check();
    pp_exp_t p;
    p.all_e = 1'b1;
    for (int k = 0; k < 4; k++) begin
      p.cur[k]   = 8'(pp_model[k]);
      p.empty[k] = (pp_model[k] == 0);
      if (pp_model[k] != 0) p.all_e = 1'b0;
    end
    pp_q.push_back(p);
    -> pp_chk;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pokemon_addr"}, 128'(pokemon_addr), 128'(0));
    chk({tag, "_move_addr"},    128'(move_addr),    128'(0));
    chk({tag, "_busy"},         128'(busy),         128'(0));
    chk({tag, "_done"},         128'(done),         128'(0));
    chk({tag, "_type1"},        128'(mon_type1),    128'(0));
    chk({tag, "_type2"},        128'(mon_type2),    128'(0));
    chk({tag, "_base"},         128'(mon_base),     128'(0));
    chk({tag, "_move_info"},    128'(move_info),    128'(0));
    chk({tag, "_pp_max"},       128'(pp_max),       128'(0));
    chk({tag, "_pp_cur"},       128'(pp_cur),       128'(0));
    chk({tag, "_pp_empty"},     128'(pp_empty),     128'(4'hF));
    chk({tag, "_all_empty"},    128'(all_pp_empty), 128'(1));
  endtask

  // ---------------- stimulus ----------------
  task automatic do_load(input int sel, input bit spam_start, input bit spam_use,
                         input bit use_with_start);
    int busy_n;
    int done_n;
    int done_at;
    logic [4:0] seen [4];
    exp_t e;
    @(negedge clk);
    start    = 1'b1;
    mon_sel  = 3'(sel);
    use_move = use_with_start;
    move_idx = 2'($urandom_range(0, 3));
    e = model_load(sel);
    exp_q.push_back(e);
    for (int k = 0; k < 4; k++) begin
      pp_model[k]    = int'(e.ppm[k]);
      ppmax_model[k] = int'(e.ppm[k]);
    end
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        done_n++;
        done_at = n;
      end
      if (n >= 2 && n <= 5) seen[n-2] = move_addr;
      start    = (n <= 6) ? spam_start : 1'b0;
      mon_sel  = 3'($urandom_range(0, 7));
      use_move = (n <= 6) ? spam_use : 1'b0;
      move_idx = 2'($urandom_range(0, 3));
    end
    chk("busy_cycles", 128'(busy_n), 128'(6));
    chk("done_cycles", 128'(done_n), 128'(1));
    chk("done_cycle_index", 128'(done_at), 128'(6));
    for (int k = 0; k < 4; k++)
      chk("move_addr_seq", 128'(seen[k]), 128'(mon_mv[sel][k] % 8'd32));
    pp_check();
  endtask

  task automatic use_slot(input int s);
    @(negedge clk);
    use_move = 1'b1;
    move_idx = 2'(s);
    if (pp_model[s] > 0) pp_model[s]--;
    @(negedge clk);
    use_move = 1'b0;
    pp_check();
  endtask

`ifdef BATTLE_STATS_REFILL_EN
  task automatic do_refill(input bit with_use, input int s);
    @(negedge clk);
    refill   = 1'b1;
    use_move = with_use;
    move_idx = 2'(s);
    for (int k = 0; k < 4; k++) pp_model[k] = ppmax_model[k];
    @(negedge clk);
    refill   = 1'b0;
    use_move = 1'b0;
    pp_check();
  endtask
`endif

  task automatic reset_mid_load(input int sel);
    exp_t d;
    @(negedge clk);
    start   = 1'b1;
    mon_sel = 3'(sel);
    exp_q.push_back(model_load(sel));
    @(negedge clk);            // FETCH_MON
    start = 1'b0;
    @(negedge clk);            // FETCH_MV slot 0
    @(negedge clk);            // FETCH_MV slot 1
    #2 reset_n = 1'b0;
    #1 check_reset_vals("midrst");
    d = exp_q.pop_back();
    for (int k = 0; k < 4; k++) begin
      pp_model[k]    = 0;
      ppmax_model[k] = 0;
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_busy_after", 128'(busy), 128'(0));
    chk("midrst_done_after", 128'(done), 128'(0));
    pp_check();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // random table, then the entries the directed checks rely on
    for (int m = 0; m < 8; m++) begin
      mon_t1[m] = 8'($urandom_range(0, 17));
      mon_t2[m] = 8'($urandom_range(0, 18));
      for (int j = 0; j < 6; j++) mon_st[m][j] = 8'($urandom_range(20, 150));
      for (int k = 0; k < 4; k++) mon_mv[m][k] = 8'($urandom_range(0, 31));
    end
    for (int a = 0; a < 32; a++) begin
      mv_type[a] = 8'($urandom_range(0, 17));
      mv_cat[a]  = 8'($urandom_range(0, 1));
      mv_pow[a]  = 8'($urandom_range(0, 150));
      mv_acc[a]  = 8'($urandom_range(50, 100));
      mv_pp[a]   = 8'($urandom_range(1, 12));
    end
    mon_t1[0] = 8'd10; mon_t2[0] = 8'd18;
    mon_st[0][0] = 8'd79;  mon_st[0][1] = 8'd83; mon_st[0][2] = 8'd100;
    mon_st[0][3] = 8'd85;  mon_st[0][4] = 8'd105; mon_st[0][5] = 8'd78;
    for (int k = 0; k < 4; k++) begin
      mon_mv[0][k] = 8'(k);
      mon_mv[3][k] = 8'(8 + k);
      mon_mv[5][k] = 8'(12 + k);
      mon_mv[7][k] = 8'(20 + k);
    end
    mon_st[5][0] = 8'd35;
    mv_type[0] = 8'd10; mv_cat[0] = 8'd0; mv_pow[0] = 8'd110; mv_acc[0] = 8'd80;  mv_pp[0] = 8'd5;
    mv_type[1] = 8'd14; mv_cat[1] = 8'd0; mv_pow[1] = 8'd90;  mv_acc[1] = 8'd100; mv_pp[1] = 8'd10;
    mv_type[13] = 8'd0;  mv_cat[13] = 8'd1; mv_pow[13] = 8'd80;  mv_acc[13] = 8'd75; mv_pp[13] = 8'd20;
    mv_type[15] = 8'd12; mv_cat[15] = 8'd0; mv_pow[15] = 8'd110; mv_acc[15] = 8'd70; mv_pp[15] = 8'd10;
    mv_pp[20] = 8'd10; mv_pp[21] = 8'd15; mv_pp[22] = 8'd5; mv_pp[23] = 8'd10;
    mv_pp[10] = 8'd15;

    reset_n  = 1'b0;
    start    = 1'b0;
    mon_sel  = 3'd0;
    use_move = 1'b0;
    move_idx = 2'd0;
`ifdef BATTLE_STATS_REFILL_EN
    refill   = 1'b0;
`endif
    for (int k = 0; k < 4; k++) begin
      pp_model[k]    = 0;
      ppmax_model[k] = 0;
    end
    #1 check_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    pp_check();

    // species 0, then six uses of slot 0 (saturates at zero)
    do_load(0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) use_slot(0);

    // species 5, then drain every slot
    do_load(5, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 4; s++)
      while (pp_model[s] > 0) use_slot(s);
    use_slot(2);

    // species 7 reloads PP
    do_load(7, 1'b0, 1'b0, 1'b0);

    // start/use ignored while busy; use dropped when issued with start
    do_load(2, 1'b1, 1'b0, 1'b0);
    do_load(4, 1'b0, 1'b1, 1'b0);
    do_load(6, 1'b1, 1'b1, 1'b1);
    use_slot(1);

    // reset during FETCH_MV
    reset_mid_load(5);
    use_slot(3);

    // randomized mix of loads and PP uses
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 3)
        do_load(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        use_slot(int'($urandom_range(0, 3)));
    end

`ifdef BATTLE_STATS_REFILL_EN
    do_load(3, 1'b0, 1'b0, 1'b0);
    while (pp_model[2] > 0) use_slot(2);
    do_refill(1'b0, 0);
    chk("refill_slot2", 128'(pp_model[2]), 128'(15));
    use_slot(1);
    do_refill(1'b1, 1);
`endif

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL pending_loads: got %0d outstanding expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
